// File: rtl/regfile_mp_if.sv
// regfile_mp_if: read/write/scoreboard bus of the multi-port register file
interface regfile_mp_if #(
  parameter int DW = 64,
  parameter int AW = 5,
  parameter int NR = 2,
  parameter int NW = 1
);
  logic [NW-1:0]    wen;
  logic [NW*AW-1:0] waddr;
  logic [NW*DW-1:0] wdata;
  logic [NR*AW-1:0] raddr;
  logic [NR*DW-1:0] rdata;
  logic [NR-1:0]    rbusy;
  logic             sb_set;
  logic [AW-1:0]    sb_addr;
  logic             ready;
  logic             a0zero;
  modport master (output wen, waddr, wdata, raddr, sb_set, sb_addr,
                  input rdata, rbusy, ready, a0zero);
  modport slave (input wen, waddr, wdata, raddr, sb_set, sb_addr,
                 output rdata, rbusy, ready, a0zero);
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: NR-read/NW-write register file with busy scoreboard and zero sweep; REGFILE_BYPASS_EN adds write-to-read forwarding
module regfile_mp #(
  parameter int DW    = 64,
  parameter int DEPTH = 32,
  parameter int NR    = 2,
  parameter int NW    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  regfile_mp_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {INIT, READY} state_t;
  state_t            state, state_nx;
  logic [AW-1:0]     cnt;
  logic [DW-1:0]     regs [DEPTH];
  logic [DEPTH-1:0]  busy, busy_nx;
  logic [NR*DW-1:0]  rdata_c;
  logic [NR-1:0]     rbusy_c;
  // state register and sweep counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= (state == INIT) ? cnt + 1'b1 : '0;
    end
  end
  // leave INIT once the last register has been swept
  always_comb begin
    state_nx = state;
    if (state == INIT && cnt == AW'(DEPTH - 1)) state_nx = READY;
  end
  assign bus.ready = (state == READY);
  // storage: zero sweep in INIT, ascending port loop so the highest port wins
  always_ff @(posedge clk) begin
    if (state == INIT) regs[cnt] <= '0;
    else
      for (int k = 0; k < NW; k++)
        if (bus.wen[k] && bus.waddr[k*AW +: AW] != '0)
          regs[bus.waddr[k*AW +: AW]] <= bus.wdata[k*DW +: DW];
  end
  // scoreboard update: writebacks clear, issue sets afterwards so set wins
  always_comb begin
    busy_nx = busy;
    for (int k = 0; k < NW; k++)
      if (bus.wen[k]) busy_nx[bus.waddr[k*AW +: AW]] = 1'b0;
    if (bus.sb_set) busy_nx[bus.sb_addr] = 1'b1;
    busy_nx[0] = 1'b0;
  end
  // scoreboard register, frozen while sweeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else if (state == READY) busy <= busy_nx;
  end
  // read ports: zero in INIT and for address 0, optional same-cycle forwarding
  always_comb begin
    logic [AW-1:0] ra;
    ra      = '0;
    rdata_c = '0;
    rbusy_c = '0;
    for (int j = 0; j < NR; j++) begin
      ra = bus.raddr[j*AW +: AW];
      if (state == READY && ra != '0) begin
        rdata_c[j*DW +: DW] = regs[ra];
        rbusy_c[j]          = busy[ra];
`ifdef REGFILE_BYPASS_EN
        for (int k = 0; k < NW; k++)
          if (bus.wen[k] && bus.waddr[k*AW +: AW] == ra) begin
            rdata_c[j*DW +: DW] = bus.wdata[k*DW +: DW];
            rbusy_c[j]          = (bus.sb_set && bus.sb_addr == ra) ? busy[ra] : 1'b0;
          end
`else
`endif
      end
    end
  end
  assign bus.rdata = rdata_c;
  assign bus.rbusy = rbusy_c;
  if (DEPTH > 10) begin : g_a0
    assign bus.a0zero = ~|regs[10];
  end else begin : g_na0
    assign bus.a0zero = 1'b1;
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed self-checking bench for regfile_mp (DEPTH=32, NR=2, NW=2)
module tb_regfile_mp;
  localparam int DW = 64, DEPTH = 32, AW = 5, NR = 2, NW = 2;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   n;
  regfile_mp_if #(.DW(DW), .AW(AW), .NR(NR), .NW(NW)) bus ();
  regfile_mp #(.DW(DW), .DEPTH(DEPTH), .NR(NR), .NW(NW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    bus.wen = '0; bus.waddr = '0; bus.wdata = '0; bus.sb_set = 1'b0; bus.sb_addr = '0;
  endtask
  task automatic wr(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.wen[k] = 1'b1;
    bus.waddr[k*AW +: AW] = a;
    bus.wdata[k*DW +: DW] = d;
  endtask
  task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    bus.raddr = {a1, a0};
    #1;
  endtask
  task automatic wait_ready(input string tag);
    n = 0;
    while (!bus.ready && n < 100) begin
      step();
      n++;
      if (n == 20) begin
        wr(0, 5'd12, 64'h55);
        bus.sb_set = 1'b1; bus.sb_addr = 5'd12;
      end
      if (n == 21) idle();
    end
    chk(tag, 64'(n), 64'd32);
  endtask
  initial begin
    idle();
    bus.raddr = '0;
    #12;
    chk("rst_ready", 64'(bus.ready), 64'd0);
    rd(5'd3, 5'd4);
    chk("rst_rbusy", 64'(bus.rbusy), 64'd0);
    step();
    rst_n = 1'b1;
    wait_ready("init_lat");
    for (int a = 0; a < DEPTH; a++) begin
      rd(5'(a), 5'(DEPTH - 1 - a));
      chk("sweep_r0", bus.rdata[63:0], 64'd0);
      chk("sweep_r1", bus.rdata[127:64], 64'd0);
    end
    chk("sweep_busy", 64'(bus.rbusy), 64'd0);
    chk("a0zero_init", 64'(bus.a0zero), 64'd1);
    rd(5'd5, 5'd5);
    wr(0, 5'd5, 64'hDEAD_BEEF);
    #1;
    chk("w5_same", bus.rdata[63:0], BYP ? 64'hDEAD_BEEF : 64'd0);
    step();
    idle();
    #1;
    chk("w5_r0", bus.rdata[63:0], 64'hDEAD_BEEF);
    chk("w5_r1", bus.rdata[127:64], 64'hDEAD_BEEF);
    wr(0, 5'd0, 64'h1234);
    step();
    idle();
    rd(5'd0, 5'd5);
    chk("w0_r0", bus.rdata[63:0], 64'd0);
    wr(0, 5'd7, 64'h11);
    wr(1, 5'd7, 64'h22);
    step();
    idle();
    rd(5'd7, 5'd7);
    chk("w7_prio", bus.rdata[127:64], 64'h22);
    rd(5'd3, 5'd4);
    bus.sb_set = 1'b1; bus.sb_addr = 5'd3;
    step();
    idle();
    #1;
    chk("sb_set3", 64'(bus.rbusy), 64'd1);
    wr(0, 5'd3, 64'h33);
    #1;
    chk("wb3_same", 64'(bus.rbusy), BYP ? 64'd0 : 64'd1);
    step();
    idle();
    #1;
    chk("wb3_clr", 64'(bus.rbusy), 64'd0);
    chk("wb3_data", bus.rdata[63:0], 64'h33);
    bus.sb_set = 1'b1; bus.sb_addr = 5'd3;
    wr(1, 5'd3, 64'h44);
    step();
    idle();
    #1;
    chk("set_wins", 64'(bus.rbusy), 64'd1);
    chk("set_data", bus.rdata[63:0], 64'h44);
    bus.sb_set = 1'b1; bus.sb_addr = 5'd0;
    step();
    idle();
    rd(5'd0, 5'd3);
    chk("busy0", 64'(bus.rbusy), 64'b10);
    wr(0, 5'd9, 64'h777);
    step();
    idle();
    rd(5'd9, 5'd1);
    wr(1, 5'd9, 64'hABC);
    #1;
    chk("byp_same", bus.rdata[63:0], BYP ? 64'hABC : 64'h777);
    step();
    idle();
    #1;
    chk("byp_next", bus.rdata[63:0], 64'hABC);
    wr(0, 5'd10, 64'h1);
    step();
    idle();
    #1;
    chk("a0zero_set", 64'(bus.a0zero), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 64'(bus.ready), 64'd0);
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) step();
    rst_n = 1'b0;
    rd(5'd3, 5'd12);
    chk("sweep_rst_ready", 64'(bus.ready), 64'd0);
    chk("sweep_rst_busy", 64'(bus.rbusy), 64'd0);
    step();
    rst_n = 1'b1;
    wait_ready("restart_lat");
    rd(5'd12, 5'd5);
    chk("init_wr_drop", bus.rdata[63:0], 64'd0);
    chk("resweep5", bus.rdata[127:64], 64'd0);
    chk("init_sb_drop", 64'(bus.rbusy), 64'd0);
    rd(5'd3, 5'd9);
    chk("rst_busy3", 64'(bus.rbusy), 64'd0);
    chk("resweep9", bus.rdata[127:64], 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
